// File: rtl/gap_buf_pkg.sv
// Shared types and default sizes for the GAP -> SE vector buffer.
// Pooling and SE FC stages import the same defaults.
package gap_buf_pkg;

    localparam int GAP_DATA_W = 9;
    localparam int GAP_NUM_CH = 32;

    typedef enum logic {
        W_FILL,
        W_DROP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } r_state_t;

endpackage

// File: rtl/gap_vec_bank.sv
// Two-bank channel register file: one write port, one async read port.
// Contents are deliberately left unreset.
module gap_vec_bank #(
    parameter int DATA_W = 9,
    parameter int NUM_CH = 32,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_wr_bank,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_bank,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2][NUM_CH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_bank][i_rd_idx];

endmodule

// File: rtl/gap_vector_buffer.sv
// Ping-pong squeeze-vector buffer between GAP and the SE FC stage.
// Whole vectors are dropped when the target bank is still occupied.
module gap_vector_buffer
    import gap_buf_pkg::*;
#(
    parameter int DATA_W = GAP_DATA_W,
    parameter int NUM_CH = GAP_NUM_CH,
    parameter int IDX_W  = $clog2(NUM_CH),
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_ch_idx,
    output logic              out_last,
    output logic              vec_done,
    output logic              overflow_err,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    w_state_t          r_wstate;
    r_state_t          r_rstate;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [1:0]        r_full;
    logic              r_vec_done;
    logic              r_ovf;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_blocked;
    logic              w_we;
    logic              w_out_valid;
    logic              w_xfer;
    logic              w_rd_last;
    logic [1:0]        w_set;
    logic [1:0]        w_clr;
    logic [DATA_W-1:0] w_rd_data;

    // Bank choice is made only at vector start, using registered full.
    assign w_blocked = in_valid && (r_wstate == W_FILL)
                     && (r_wr_idx == '0) && r_full[r_wr_bank];
    assign w_we      = in_valid && !flush
                     && (r_wstate == W_FILL) && !w_blocked;

    assign w_out_valid = (r_rstate == R_STREAM);
    assign w_xfer      = w_out_valid && out_ready;
    assign w_rd_last   = w_xfer && (r_rd_idx == LAST);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_we && (r_wr_idx == LAST)) w_set[r_wr_bank] = 1'b1;
        if (w_rd_last)                  w_clr[r_rd_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) r_full <= '0;
        else                r_full <= (r_full | w_set) & ~w_clr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate   <= W_FILL;
            r_wr_bank  <= 1'b0;
            r_wr_idx   <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_wstate  <= W_FILL;
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else if (in_valid) begin
            r_wr_idx <= (r_wr_idx == LAST) ? '0 : r_wr_idx + 1'b1;
            case (r_wstate)
                W_FILL: begin
                    if (w_blocked) begin
                        r_ovf <= 1'b1;
                        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
                        if (r_wr_idx != LAST) r_wstate <= W_DROP;
                    end else if (r_wr_idx == LAST) begin
                        r_wr_bank <= ~r_wr_bank;
                    end
                end
                W_DROP: begin
                    if (r_wr_idx == LAST) r_wstate <= W_FILL;
                end
                default: r_wstate <= W_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rstate   <= R_IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_idx   <= '0;
            r_vec_done <= 1'b0;
        end else begin
            r_vec_done <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (r_full[r_rd_bank]) r_rstate <= R_STREAM;
                end
                R_STREAM: begin
                    if (w_rd_last) begin
                        r_rd_idx   <= '0;
                        r_rd_bank  <= ~r_rd_bank;
                        r_rstate   <= R_IDLE;
                        r_vec_done <= 1'b1;
                    end else if (w_xfer) begin
                        r_rd_idx <= r_rd_idx + 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    gap_vec_bank #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_bank (r_wr_bank),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (in_data),
        .i_rd_bank (r_rd_bank),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_data)
    );

    assign out_valid    = w_out_valid;
    assign out_data     = w_out_valid ? w_rd_data : '0;
    assign out_ch_idx   = r_rd_idx;
    assign out_last     = w_out_valid && (r_rd_idx == LAST);
    assign vec_done     = r_vec_done;
    assign overflow_err = r_ovf;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_gap_vector_buffer.sv
// Directed bench: 4-channel instance for streaming/overflow/flush,
// 32-channel instance for reset during a partial fill.
module tb_gap_vector_buffer;

    logic       clk;
    logic       rst4, fl4, iv4, or4;
    logic [8:0] id4;
    logic       ov4, last4, vd4, oe4;
    logic [8:0] od4;
    logic [1:0] idx4;
    logic [1:0] dc4;

    logic       rst32, fl32, iv32, or32;
    logic [8:0] id32;
    logic       ov32, last32, vd32, oe32;
    logic [8:0] od32;
    logic [4:0] idx32;
    logic [7:0] dc32;

    int n_chk;
    int n_fail;

    gap_vector_buffer #(.DATA_W(9), .NUM_CH(4), .DROP_W(2)) dut4 (
        .clk(clk), .reset(rst4), .flush(fl4),
        .in_valid(iv4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .out_ch_idx(idx4), .out_last(last4), .vec_done(vd4),
        .overflow_err(oe4), .drop_cnt(dc4)
    );

    gap_vector_buffer #(.DATA_W(9), .NUM_CH(32), .DROP_W(8)) dut32 (
        .clk(clk), .reset(rst32), .flush(fl32),
        .in_valid(iv32), .in_data(id32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32),
        .out_ch_idx(idx32), .out_last(last32), .vec_done(vd32),
        .overflow_err(oe32), .drop_cnt(dc32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send4(input logic [8:0] a, input logic [8:0] b,
                         input logic [8:0] c, input logic [8:0] d);
        logic [8:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv4 = 1'b1;
            id4 = v[i];
        end
        @(negedge clk);
        iv4 = 1'b0;
        id4 = '0;
    endtask

    task automatic recv4(input string tag,
                         input logic [8:0] a, input logic [8:0] b,
                         input logic [8:0] c, input logic [8:0] d);
        logic [8:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_valid"}, 32'(ov4), 1);
            check({tag, "_data"}, 32'(od4), 32'(v[i]));
            check({tag, "_idx"}, 32'(idx4), i);
            check({tag, "_last"}, 32'(last4), (i == 3) ? 1 : 0);
            @(negedge clk);
        end
        check({tag, "_end_valid"}, 32'(ov4), 0);
        check({tag, "_vec_done"}, 32'(vd4), 1);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst4 = 1'b1; fl4 = 1'b0; iv4 = 1'b0; or4 = 1'b1; id4 = '0;
        rst32 = 1'b1; fl32 = 1'b0; iv32 = 1'b0; or32 = 1'b1; id32 = '0;

        @(negedge clk);
        check("rst_valid", 32'(ov4), 0);
        check("rst_data", 32'(od4), 0);
        check("rst_idx", 32'(idx4), 0);
        check("rst_last", 32'(last4), 0);
        check("rst_vdone", 32'(vd4), 0);
        check("rst_ovf", 32'(oe4), 0);
        check("rst_drop", 32'(dc4), 0);
        rst4 = 1'b0;
        rst32 = 1'b0;

        // Basic streaming and two-edge latency
        send4(10, 20, 30, 40);
        check("basic_lat_edge1", 32'(ov4), 0);
        @(negedge clk);
        recv4("basic", 10, 20, 30, 40);
        @(negedge clk);
        check("basic_vdone_pulse", 32'(vd4), 0);
        check("basic_ovf", 32'(oe4), 0);

        // Backpressure hold
        or4 = 1'b0;
        send4(10, 20, 30, 40);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(ov4), 1);
            check("hold_data", 32'(od4), 10);
            check("hold_idx", 32'(idx4), 0);
            @(negedge clk);
        end
        or4 = 1'b1;
        recv4("hold", 10, 20, 30, 40);

        // Ping-pong with one idle bubble
        or4 = 1'b0;
        send4(1, 2, 3, 4);
        send4(5, 6, 7, 8);
        or4 = 1'b1;
        recv4("pp_a", 1, 2, 3, 4);
        @(negedge clk);
        recv4("pp_b", 5, 6, 7, 8);
        check("pp_ovf", 32'(oe4), 0);

        // Overflow: third vector is dropped
        or4 = 1'b0;
        send4(1, 2, 3, 4);
        send4(5, 6, 7, 8);
        send4(9, 10, 11, 12);
        check("ovf_flag", 32'(oe4), 1);
        check("ovf_drop", 32'(dc4), 1);
        check("ovf_hold_data", 32'(od4), 1);
        or4 = 1'b1;
        recv4("ovf_a", 1, 2, 3, 4);
        @(negedge clk);
        recv4("ovf_b", 5, 6, 7, 8);
        @(negedge clk);
        check("ovf_no_c", 32'(ov4), 0);
        send4(13, 14, 15, 16);
        check("ovf_d_lat", 32'(ov4), 0);
        @(negedge clk);
        recv4("ovf_d", 13, 14, 15, 16);
        check("ovf_drop_keep", 32'(dc4), 1);

        // Flush mid-stream at idx 2
        send4(31, 32, 33, 34);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("fl_idx2", 32'(idx4), 2);
        check("fl_data2", 32'(od4), 33);
        fl4 = 1'b1;
        @(negedge clk);
        fl4 = 1'b0;
        check("fl_valid", 32'(ov4), 0);
        check("fl_vdone", 32'(vd4), 0);
        check("fl_ovf_keep", 32'(oe4), 1);
        check("fl_drop_keep", 32'(dc4), 1);
        @(negedge clk);
        check("fl_idle", 32'(ov4), 0);
        send4(21, 22, 23, 24);
        @(negedge clk);
        recv4("fl_new", 21, 22, 23, 24);

        // drop_cnt saturates at 3 with a 2-bit counter
        or4 = 1'b0;
        send4(41, 42, 43, 44);
        send4(45, 46, 47, 48);
        send4(50, 51, 52, 53);
        send4(54, 55, 56, 57);
        send4(58, 59, 60, 61);
        check("sat_drop", 32'(dc4), 3);
        check("sat_ovf", 32'(oe4), 1);
        check("sat_head", 32'(od4), 41);

        // Reset during a partial fill of a 32-channel vector
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            iv32 = 1'b1;
            id32 = 9'(i + 1);
        end
        @(negedge clk);
        iv32 = 1'b0;
        rst32 = 1'b1;
        @(negedge clk);
        rst32 = 1'b0;
        check("r32_valid", 32'(ov32), 0);
        check("r32_data", 32'(od32), 0);
        check("r32_idx", 32'(idx32), 0);
        check("r32_last", 32'(last32), 0);
        check("r32_vdone", 32'(vd32), 0);
        check("r32_ovf", 32'(oe32), 0);
        check("r32_drop", 32'(dc32), 0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            iv32 = 1'b1;
            id32 = 9'(100 + i);
        end
        @(negedge clk);
        iv32 = 1'b0;
        check("r32_lat_edge1", 32'(ov32), 0);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            check("r32_s_valid", 32'(ov32), 1);
            check("r32_s_data", 32'(od32), 100 + i);
            check("r32_s_idx", 32'(idx32), i);
            check("r32_s_last", 32'(last32), (i == 31) ? 1 : 0);
            @(negedge clk);
        end
        check("r32_end_valid", 32'(ov32), 0);
        check("r32_vec_done", 32'(vd32), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gap_vector_buffer.md
Name: gap_vector_buffer

Overview:
- Sits directly downstream of the global-average-pooling stage.
- Collects the per-channel average pulses (one value per channel, channel order 0..NUM_CH-1) into a full squeeze vector.
- Streams completed vectors to the SE fully-connected stage over a valid/ready handshake.
- Uses ping-pong banks so the pooling stage, which has no backpressure, can keep producing while the previous vector drains.

Parameters:
- DATA_W, 9: width of one channel average.
- NUM_CH, 32: channels per squeeze vector.
- IDX_W, $clog2(NUM_CH): channel index width.
- DROP_W, 8: width of the saturating dropped-vector counter.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronous soft clear of pointers/flags; keeps overflow_err and drop_cnt.
- in_valid, input, 1: average-pooling result pulse.
- in_data, input, DATA_W: channel average, unsigned.
- out_valid, output, 1: element available to the FC stage.
- out_ready, input, 1: FC stage accepts the element.
- out_data, output, DATA_W: channel value; 0 when out_valid=0.
- out_ch_idx, output, IDX_W: channel index of out_data.
- out_last, output, 1: high with the element at index NUM_CH-1.
- vec_done, output, 1: one-cycle pulse after the last element of a vector is transferred.
- overflow_err, output, 1: sticky; a vector was dropped.
- drop_cnt, output, DROP_W: count of dropped vectors, saturating.

Behaviour:
- Reset values: out_valid=0, out_last=0, vec_done=0, overflow_err=0, drop_cnt=0, out_ch_idx=0, out_data=0. Internally wr_bank=0, rd_bank=0, wr_idx=0, rd_idx=0, full[1:0]=0, write FSM=W_FILL, read FSM=R_IDLE. Bank contents are not reset.
- Write FSM, states W_FILL and W_DROP:
  - The bank decision is taken only at vector start (wr_idx==0 && in_valid).
  - Start with full[wr_bank]==0: write in_data to bank[wr_bank][0], stay in W_FILL.
  - Start with full[wr_bank]==1: go to W_DROP, set overflow_err, increment drop_cnt (saturating at all-ones). The element is discarded.
  - Each in_valid advances wr_idx in both states.
  - When in_valid arrives with wr_idx==NUM_CH-1:
    - In W_FILL: write the element, set full[wr_bank], toggle wr_bank.
    - In W_DROP: return to W_FILL; wr_bank is unchanged.
    - In both states: wr_idx wraps to 0.
  - Dropping a whole vector keeps channel alignment with the pooling stream.
  - in_valid with wr_idx mid-vector is never blocked: the bank was reserved at vector start and is not full.
- Read FSM, states R_IDLE and R_STREAM:
  - R_IDLE with full[rd_bank]==1: go to R_STREAM on the next edge.
  - out_valid = (state==R_STREAM).
  - out_data = bank[rd_bank][rd_idx] and out_ch_idx = rd_idx, both combinational from registered state.
  - Transfer occurs when out_valid && out_ready. On transfer rd_idx increments.
  - On transfer with rd_idx==NUM_CH-1: clear full[rd_bank], toggle rd_bank, rd_idx wraps to 0, return to R_IDLE, pulse vec_done on the following cycle.
  - There is always one idle bubble between vectors.
- Latency: from the edge capturing the last input element, out_valid rises after 2 edges. Edge 1 sets full; edge 2 enters R_STREAM.
- Stability: while out_valid && !out_ready, out_data, out_ch_idx and out_last hold. The write side never targets a full bank.
- Simultaneous events:
  - Full clear on the read side and a vector start on the write side in the same cycle: the write side sees the registered full=1 and drops that vector.
  - Full set on the write side while the other bank streams is legal. Both banks may be full at once.
- flush or reset mid-operation: takes effect on that edge. Both vectors are abandoned, out_valid falls the next cycle, and a partially written vector is discarded. in_valid during a flush cycle is ignored.
- Arithmetic: wr_idx and rd_idx wrap at NUM_CH; NUM_CH need not be a power of two. drop_cnt saturates and does not wrap.

Decomposition:
- Package gap_buf_pkg holds:
  - typedef enum w_state_t {W_FILL, W_DROP};
  - typedef enum r_state_t {R_IDLE, R_STREAM};
  - DATA_W and NUM_CH defaults, shared with the pooling stage and the SE FC stage.
- Sub-module gap_vec_bank: 2×NUM_CH×DATA_W register file with one write port (bank, idx, data, we) and one combinational read port (bank, idx).

Test Plan (NUM_CH=4 unless noted):
- Basic streaming: reset; in_valid pulses with data 10, 20, 30, 40; out_ready=1.
  - out_valid rises 2 edges after 40 is captured.
  - out_data 10, 20, 30, 40 with out_ch_idx 0..3; out_last only on 40; vec_done pulses once; overflow_err=0.
- Backpressure hold: same vector with out_ready=0 for 5 cycles, then 1.
  - out_data holds 10 and idx 0 for all 5 cycles, then streams the four values in order.
- Ping-pong: out_ready=0; send vector A (1..4) then vector B (5..8); release out_ready.
  - Outputs 1..4, one idle cycle, then 5..8; no drop.
- Overflow: out_ready=0; send vectors A, B, C (9..12).
  - C is dropped; overflow_err=1; drop_cnt=1.
  - Releasing out_ready yields A then B only.
  - Next vector D (13..16) is stored and streamed.
- Flush mid-stream: during streaming at idx 2, assert flush for 1 cycle.
  - out_valid=0 next cycle; overflow_err and drop_cnt unchanged.
  - A new vector 21..24 streams from idx 0.
- Reset mid-fill with NUM_CH=32: after 17 inputs, assert reset.
  - All outputs return to reset values.
  - The next 32 inputs form a complete vector streamed from idx 0.
